ps2_keyboard: RTL and testbench

PS/2 host-side receiver: samples the keyboard clock/data lines, deserialises 11-bit device-to-host frames and validates start/parity/stop. Good bytes are pushed into a first-word-fall-through FIFO. Two read strobes (keyboard consumer and debug consumer) pop the FIFO; status flags report occupancy. Receive-only; the block never drives the PS/2 lines.

---
 rtl/ps2_keyboard.sv | 160 ++++++++++++++++
 tb/tb_ps2_keyboard.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/ps2_keyboard.sv
// PS/2 host-side receiver: synchronises the keyboard clock/data lines, checks framing
// and odd parity, and queues good bytes in a first-word-fall-through FIFO.
module ps2_keyboard #(
  parameter int FIFO_DEPTH     = 16,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  input  logic       rd_kbrd,
  input  logic       rd_dbug,
  output logic [7:0] rd_data,
  output logic       data_present,
  output logic       data_half,
  output logic       data_full
);

  // state  | meaning
  // IDLE   | waiting for a falling edge carrying a 0 start bit
  // DATA   | shifting in D0..D7, LSB first
  // PARITY | capturing the parity bit
  // STOP   | checking stop bit and odd parity, writing the byte if good

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LOAD  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [AW:0]   CNT_HALF  = (AW + 1)'(FIFO_DEPTH / 2);
  localparam logic [AW:0]   CNT_FULL  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } rx_state_t;

  logic clk_s1, clk_s2, clk_s3;
  logic dat_s1, dat_s2;
  logic fall;

  rx_state_t       state;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift;
  logic            par;
  logic [TW-1:0]   tmo_cnt;
  logic            wr_en;
  logic [7:0]      wr_byte;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr, rd_ptr_n;
  logic [AW:0]     count, count_n;
  logic [7:0]      head_n;
  logic            do_wr, do_rd;

  // Lines idle high, so the synchronisers reset to 1 to avoid a false edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      clk_s3 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      clk_s3 <= clk_s2;
      dat_s1 <= ps2_dat;
      dat_s2 <= dat_s1;
    end
  end

  assign fall = clk_s3 & ~clk_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
      shift   <= '0;
      par     <= 1'b0;
      tmo_cnt <= '0;
      wr_en   <= 1'b0;
      wr_byte <= '0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        S_IDLE: begin
          tmo_cnt <= TMO_LOAD;
          bit_cnt <= '0;
          if (fall && !dat_s2) state <= S_DATA;
        end
        default: begin
          if (fall) begin
            tmo_cnt <= TMO_LOAD;
            case (state)
              S_DATA: begin
                shift   <= {dat_s2, shift[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) state <= S_PARITY;
              end
              S_PARITY: begin
                par   <= dat_s2;
                state <= S_STOP;
              end
              S_STOP: begin
                if (dat_s2 && ((^shift) ^ par)) begin
                  wr_en   <= 1'b1;
                  wr_byte <= shift;
                end
                state <= S_IDLE;
              end
              default: state <= S_IDLE;
            endcase
          end else if (tmo_cnt == '0) begin
            state <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt - 1'b1;
          end
        end
      endcase
    end
  end

  // A write arriving while full is dropped even if a pop frees a slot this cycle.
  assign do_rd = (rd_kbrd | rd_dbug) & data_present;
  assign do_wr = wr_en & ~data_full;

  always_comb begin
    rd_ptr_n = do_rd ? rd_ptr + AW'(1) : rd_ptr;
    count_n  = count;
    if (do_wr && !do_rd)      count_n = count + (AW + 1)'(1);
    else if (!do_wr && do_rd) count_n = count - (AW + 1)'(1);
    head_n = (do_wr && (wr_ptr == rd_ptr_n)) ? wr_byte : mem[rd_ptr_n];
  end

  always_ff @(posedge clk) begin
    if (!rst && do_wr) mem[wr_ptr] <= wr_byte;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      rd_data      <= '0;
      data_present <= 1'b0;
      data_half    <= 1'b0;
      data_full    <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr       <= rd_ptr_n;
      count        <= count_n;
      data_present <= (count_n != '0);
      data_half    <= (count_n >= CNT_HALF);
      data_full    <= (count_n == CNT_FULL);
      if (count_n != '0) rd_data <= head_n;
    end
  end

endmodule

// File: tb/tb_ps2_keyboard.sv
// Randomised scoreboard bench for ps2_keyboard: frames are generated at the pin level,
// a byte-queue model predicts FIFO contents and a monitor checks every pop.
module tb_ps2_keyboard;

  localparam int DEPTH    = 16;
  localparam int TMO      = 300;
  localparam int HALF_BIT = 8;

  logic       clk = 1'b0;
  logic       rst, ps2_clk, ps2_dat, rd_kbrd, rd_dbug;
  logic [7:0] rd_data;
  logic       data_present, data_half, data_full;

  int checks = 0;
  int errors = 0;

  logic [7:0] model_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] exp_v;

  always #5 clk = ~clk;

  ps2_keyboard #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
    .rd_kbrd(rd_kbrd), .rd_dbug(rd_dbug), .rd_data(rd_data),
    .data_present(data_present), .data_half(data_half), .data_full(data_full)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic void chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endfunction

  task automatic check_flags(input string tag);
    chk({tag, " present"}, int'(data_present), int'(model_q.size() > 0));
    chk({tag, " half"}, int'(data_half), int'(model_q.size() >= DEPTH / 2));
    chk({tag, " full"}, int'(data_full), int'(model_q.size() == DEPTH));
    if (model_q.size() > 0) chk({tag, " head"}, int'(rd_data), int'(model_q[0]));
  endtask

  // bits[0] is the start bit; lat measures cycles from the last falling edge to data_present.
  task automatic send_bits(input logic [10:0] bits, input int nedges, input bit lat);
    int k;
    for (int i = 0; i < nedges; i++) begin
      ps2_dat = bits[i];
      tick(HALF_BIT);
      ps2_clk = 1'b0;
      if (lat && i == 10) begin
        k = 0;
        while (k < 6 && !data_present) begin
          tick(1);
          k++;
        end
        chk("latency present", int'(data_present), 1);
        chk("latency within 5", int'(k <= 5), 1);
        tick(HALF_BIT - k);
      end else begin
        tick(HALF_BIT);
      end
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
    tick(6);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
    logic par, stop, good;
    par  = ~(^d) ^ bad_par;
    stop = ~bad_stop;
    good = !bad_par && !bad_stop;
    send_bits({stop, par, d, 1'b0}, 11, good && model_q.size() == 0);
    if (good && model_q.size() < DEPTH) model_q.push_back(d);
    tick(2);
  endtask

  task automatic pop(input bit k, input bit d);
    rd_kbrd = k;
    rd_dbug = d;
    if (model_q.size() > 0) exp_q.push_back(model_q.pop_front());
    tick(1);
    rd_kbrd = 1'b0;
    rd_dbug = 1'b0;
    tick(1);
  endtask

  always @(negedge clk) begin
    if (!rst && (rd_kbrd || rd_dbug) && data_present) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop unexpected: got %02h, required no entry", rd_data);
      end else begin
        exp_v = exp_q.pop_front();
        if (rd_data !== exp_v) begin
          errors++;
          $display("FAIL pop data: got %02h, required %02h", rd_data, exp_v);
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    logic [7:0] rb;
    rst = 1'b1; ps2_clk = 1'b1; ps2_dat = 1'b1; rd_kbrd = 1'b0; rd_dbug = 1'b0;
    tick(3);
    chk("reset rd_data", int'(rd_data), 0);
    chk("reset present", int'(data_present), 0);
    chk("reset half", int'(data_half), 0);
    chk("reset full", int'(data_full), 0);
    rst = 1'b0;
    tick(2);

    send_frame(8'hAA, 1'b0, 1'b0);
    check_flags("aa");
    pop(1'b1, 1'b0);
    check_flags("aa popped");

    send_frame(8'h1C, 1'b1, 1'b0);
    check_flags("bad parity");
    send_frame(8'h5A, 1'b0, 1'b1);
    check_flags("bad stop");

    send_bits(11'h7FF, 11, 1'b0);
    check_flags("bad start");
    send_frame(8'h55, 1'b0, 1'b0);
    check_flags("after bad start");
    pop(1'b0, 1'b1);

    for (int i = 1; i <= 17; i++) begin
      send_frame(8'(i), 1'b0, 1'b0);
      check_flags("fill");
    end
    for (int i = 0; i < 16; i++) begin
      pop(i % 2 == 0, i % 2 == 1);
      check_flags("drain");
    end
    pop(1'b1, 1'b0);
    check_flags("pop empty");

    send_bits({1'b1, 1'b1, 8'hC3, 1'b0}, 4, 1'b0);
    tick(TMO + 50);
    send_frame(8'h3A, 1'b0, 1'b0);
    check_flags("after timeout");
    pop(1'b1, 1'b0);

    repeat (40) begin
      r = $urandom_range(0, 9);
      if (r < 6) begin
        rb = 8'($urandom_range(0, 255));
        send_frame(rb, r == 4, r == 5);
      end else begin
        r = $urandom_range(1, 3);
        pop(r[0], r[1]);
      end
      check_flags("random");
    end
    while (model_q.size() > 0) pop(1'b1, 1'b0);
    check_flags("random drained");

    send_frame(8'h11, 1'b0, 1'b0);
    send_frame(8'h22, 1'b0, 1'b0);
    pop(1'b1, 1'b1);
    check_flags("dual strobe");
    send_bits({1'b1, 1'b0, 8'h0F, 1'b0}, 3, 1'b0);
    rst = 1'b1;
    tick(1);
    chk("midreset rd_data", int'(rd_data), 0);
    chk("midreset present", int'(data_present), 0);
    chk("midreset half", int'(data_half), 0);
    chk("midreset full", int'(data_full), 0);
    model_q.delete();
    rst = 1'b0;
    tick(2);

    chk("expected pops consumed", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
